// File: rtl/de1_soc_demo_pll_reset_seq.sv
// de1_soc_demo_pll_reset_seq
//   Reset sequencer for the system PLL, clocked by the free-running 50 MHz
//   reference clock. It pulses the PLL reset and waits for a synchronised,
//   stable lock. It then releases one active-high reset per PLL output
//   domain in index order, and retries the PLL reset when lock never arrives.
// Ports
//   refclk        reference clock (same clock the PLL is fed from)
//   rst           asynchronous active-high reset
//   locked_in     PLL locked flag, asynchronous to refclk
//   sw_reset_req  one-cycle synchronous request to restart the whole sequence
//   pll_rst       PLL reset, active-high
//   reset_out     per-domain resets, active-high; consumers re-synchronise
//   seq_done      all resets released and lock still held
//   retry_cnt     number of lock timeouts, saturating at 255
module de1_soc_demo_pll_reset_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int NUM_RESETS          = 3,
  parameter int RELEASE_GAP_CYCLES  = 64
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked_in,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] reset_out,
  output logic                  seq_done,
  output logic [7:0]            retry_cnt
);

  // The shared counter must reach the largest terminal value of any state.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RELEASE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_GAP_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_RESETS - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        rel_idx_q, rel_idx_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    pll_rst_q, pll_rst_d;
  logic [NUM_RESETS-1:0]   reset_out_q, reset_out_d;
  logic                    seq_done_q, seq_done_d;
  logic [7:0]              retry_cnt_q, retry_cnt_d;
  logic                    locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      rel_idx_q   <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      reset_out_q <= '1;
      seq_done_q  <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_idx_q   <= rel_idx_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      reset_out_q <= reset_out_d;
      seq_done_q  <= seq_done_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], locked_in};
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    rel_idx_d   = rel_idx_q;
    pll_rst_d   = pll_rst_q;
    reset_out_d = reset_out_q;
    seq_done_d  = seq_done_q;
    retry_cnt_d = retry_cnt_q;

    // A software restart beats lock loss and timeout in the same cycle.
    if (sw_reset_req) begin
      state_d     = S_PLL_RST;
      cnt_d       = '0;
      pll_rst_d   = 1'b1;
      reset_out_d = '1;
      seq_done_d  = 1'b0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          pll_rst_d   = 1'b1;
          reset_out_d = '1;
          seq_done_d  = 1'b0;
          if (cnt_q == PLL_RST_LAST) begin
            state_d   = S_WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = S_PLL_RST;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
          end
        end
        S_STABLE: begin
          // Any low sample restarts the whole stability window from zero.
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_DONE) begin
            reset_out_d[0] = 1'b0;
            cnt_d          = '0;
            if (NUM_RESETS == 1) begin
              state_d    = S_RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d   = S_RELEASE;
              rel_idx_d = IDX_W'(1);
            end
          end
        end
        S_RELEASE: begin
          // Lock loss re-asserts everything but leaves the PLL alone.
          if (!locked_s) begin
            state_d     = S_WAIT_LOCK;
            cnt_d       = '0;
            reset_out_d = '1;
            seq_done_d  = 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            reset_out_d[rel_idx_q] = 1'b0;
            cnt_d                  = '0;
            if (rel_idx_q == LAST_IDX) begin
              state_d    = S_RUN;
              seq_done_d = 1'b1;
            end else begin
              rel_idx_d = rel_idx_q + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          cnt_d = cnt_q;
          if (!locked_s) begin
            state_d     = S_WAIT_LOCK;
            cnt_d       = '0;
            reset_out_d = '1;
            seq_done_d  = 1'b0;
          end
        end
        default: begin
          state_d     = S_PLL_RST;
          cnt_d       = '0;
          pll_rst_d   = 1'b1;
          reset_out_d = '1;
          seq_done_d  = 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign reset_out = reset_out_q;
  assign seq_done  = seq_done_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_de1_soc_demo_pll_reset_seq.sv
// tb_de1_soc_demo_pll_reset_seq
//   Scoreboard bench for the PLL reset sequencer. A timestamp-based reference
//   model steps on each refclk rising edge and queues the expected output
//   word. A monitor on the falling edge pops and compares it with the DUT.
module tb_de1_soc_demo_pll_reset_seq;

  localparam int SYNC = 2;
  localparam int PRST = 4;
  localparam int TMO  = 32;
  localparam int STBC = 8;
  localparam int NUM  = 3;
  localparam int GAP  = 4;

  localparam int M_PLL  = 0;
  localparam int M_WAIT = 1;
  localparam int M_STB  = 2;
  localparam int M_REL  = 3;
  localparam int M_RUN  = 4;

  logic           refclk = 1'b0;
  logic           rst;
  logic           locked_in;
  logic           sw_reset_req;
  logic           pll_rst;
  logic [NUM-1:0] reset_out;
  logic           seq_done;
  logic [7:0]     retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // expected word layout: {pll_rst, reset_out, seq_done, retry_cnt}
  logic [12:0] exp_q[$];

  int m_mode, m_cyc, m_enter, m_retry;
  bit m_lk[$];

  de1_soc_demo_pll_reset_seq #(
    .SYNC_STAGES        (SYNC),
    .PLL_RST_CYCLES     (PRST),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STBC),
    .NUM_RESETS         (NUM),
    .RELEASE_GAP_CYCLES (GAP)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked_in   (locked_in),
    .sw_reset_req(sw_reset_req),
    .pll_rst     (pll_rst),
    .reset_out   (reset_out),
    .seq_done    (seq_done),
    .retry_cnt   (retry_cnt)
  );

  always #5 refclk = ~refclk;

  function automatic logic [12:0] dut_word();
    return {pll_rst, reset_out, seq_done, retry_cnt};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got pll=%b rst=%b done=%b retry=%0d, want pll=%b rst=%b done=%b retry=%0d",
                 name, $time, act[12], act[11:9], act[8], act[7:0],
                 exp[12], exp[11:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_PLL;
    m_cyc   = 0;
    m_enter = 0;
    m_retry = 0;
    m_lk.delete();
    for (int i = 0; i < SYNC; i++) m_lk.push_back(1'b0);
  endtask

  task automatic model_enter(input int mode);
    m_mode  = mode;
    m_enter = m_cyc;
  endtask

  // Output word implied by the current phase and the time spent in it.
  function automatic logic [12:0] model_word();
    logic [NUM-1:0] ro;
    int e, nrel;
    e  = m_cyc - m_enter;
    ro = '1;
    if (m_mode == M_RUN) ro = '0;
    if (m_mode == M_REL) begin
      nrel = e / GAP + 1;
      for (int i = 0; i < NUM; i++) if (i < nrel) ro[i] = 1'b0;
    end
    return {(m_mode == M_PLL), ro, (m_mode == M_RUN), 8'(m_retry)};
  endfunction

  task automatic model_step();
    bit lk;
    int e;
    m_cyc++;
    lk = m_lk.pop_front();
    m_lk.push_back(locked_in);
    e = m_cyc - m_enter;
    if (sw_reset_req) model_enter(M_PLL);
    else begin
      case (m_mode)
        M_PLL:  if (e == PRST) model_enter(M_WAIT);
        M_WAIT: if (lk) model_enter(M_STB);
                else if (e == TMO) begin
                  model_enter(M_PLL);
                  if (m_retry < 255) m_retry++;
                end
        M_STB:  if (!lk) model_enter(M_WAIT);
                else if (e == STBC + 1) model_enter((NUM == 1) ? M_RUN : M_REL);
        M_REL:  if (!lk) model_enter(M_WAIT);
                else if (e == (NUM - 1) * GAP) model_enter(M_RUN);
        default: if (!lk) model_enter(M_WAIT);
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk);
      if (rst) begin
        model_reset();
        exp_q.push_back({1'b1, {NUM{1'b1}}, 1'b0, 8'd0});
      end else begin
        model_step();
        exp_q.push_back(model_word());
      end
    end
  end

  initial begin
    forever begin
      @(negedge refclk);
      if (exp_q.size() > 0) check("scoreboard", dut_word(), exp_q.pop_front());
    end
  end

  task automatic wait_pattern(input logic [NUM-1:0] pat, input string name);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge refclk);
      if (reset_out == pat) hit = 1'b1;
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: reset_out=%b never reached %b within 200 cycles", name, reset_out, pat);
    end
  endtask

  task automatic sw_pulse();
    sw_reset_req = 1'b1;
    @(negedge refclk);
    sw_reset_req = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    locked_in    = 1'b1;
    sw_reset_req = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_state", dut_word(), {1'b1, {NUM{1'b1}}, 1'b0, 8'd0});
    rst = 1'b0;

    // Clean power-up with lock tied high.
    repeat (40) @(negedge refclk);

    // Lock loss from the run state, then recovery.
    locked_in = 1'b0;
    repeat (6) @(negedge refclk);
    locked_in = 1'b1;
    repeat (40) @(negedge refclk);

    // One-cycle lock glitch landing mid stability window.
    sw_pulse();
    repeat (8) @(negedge refclk);
    locked_in = 1'b0;
    @(negedge refclk);
    locked_in = 1'b1;
    repeat (40) @(negedge refclk);

    // Software restart after the first domain has been released.
    sw_pulse();
    wait_pattern(3'b110, "wait_rel0_sw");
    sw_pulse();
    repeat (40) @(negedge refclk);

    // Asynchronous reset in the middle of the release phase.
    sw_pulse();
    wait_pattern(3'b110, "wait_rel0_rst");
    #2 rst = 1'b1;
    #1 check("async_rst", dut_word(), {1'b1, {NUM{1'b1}}, 1'b0, 8'd0});
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    repeat (40) @(negedge refclk);

    // No lock at all: repeated timeouts until the retry counter saturates.
    locked_in = 1'b0;
    repeat (300 * (PRST + TMO) + 50) @(negedge refclk);
    check("retry_saturated", {5'b0, retry_cnt}, 13'd255);
    locked_in = 1'b1;
    repeat (40) @(negedge refclk);

    // Randomised lock dropouts and software restarts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge refclk);
      if (locked_in) locked_in = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      else           locked_in = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
      sw_reset_req = ($urandom_range(0, 299) == 0);
    end
    sw_reset_req = 1'b0;
    locked_in    = 1'b1;
    repeat (5) @(negedge refclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
